// File: rtl/hsv_core_pkg.sv
// ============================================================================
// Module      : hsv_core_pkg
// Description : Shared types for the hsv core: words, execution-unit tags,
//               commit records and commit-stage FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hsv_core_pkg;

    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        EXEC_ALU         = 2'd0,
        EXEC_MEM         = 2'd1,
        EXEC_BRANCH      = 2'd2,
        EXEC_CTRL_STATUS = 2'd3
    } exec_unit_t;

    localparam int unsigned NUM_EXEC_UNITS = 4;

    typedef struct packed {
        word pc;
    } commit_data_t;

    typedef struct packed {
        word        pc;
        logic [4:0] rd;
        word        rd_value;
        logic       writeback;
        logic       jump;
        word        jump_target;
        logic       trap;
    } commit_result_t;

    typedef enum logic [1:0] {
        COMMIT_RUN   = 2'd0,
        COMMIT_FLUSH = 2'd1,
        COMMIT_HALT  = 2'd2
    } commit_state_t;

endpackage

`default_nettype wire

// File: rtl/hsv_core_commit_fifo.sv
// ============================================================================
// Module      : hsv_core_commit_fifo
// Description : Program-order FIFO of execution-unit tags with synchronous
//               clear; pointer MSB distinguishes full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_core_commit_fifo
    import hsv_core_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  exec_unit_t push_tag,
    input  logic       pop,
    input  logic       clear,
    output exec_unit_t head_tag,
    output logic       full,
    output logic       empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    exec_unit_t       mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_tag = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            // Clear dominates: a same-cycle push is dropped.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[IDX_W-1:0]] <= push_tag;
    end

endmodule

`default_nettype wire

// File: rtl/hsv_core_commit.sv
// ============================================================================
// Module      : hsv_core_commit
// Description : In-order commit stage: retires execution-unit results in
//               issue order, writes the register file, flushes and halts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_core_commit
    import hsv_core_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk_core,
    input  logic                 rst_core,
    input  logic                 issue_valid,
    input  logic [1:0]           issue_unit,
    output logic                 issue_ready,
    input  logic [3:0]           result_valid,
    output logic [3:0]           result_ready,
    input  commit_result_t [3:0] result_data,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 commit_valid,
    output commit_data_t         commit_data,
    output logic                 flush,
    output logic [31:0]          flush_target,
    output logic                 halted
);

    commit_state_t  state_q;
    commit_state_t  state_d;
    exec_unit_t     head_tag;
    commit_result_t head_res;
    logic           fifo_full;
    logic           fifo_empty;
    logic           accept;
    logic           take_jump;
    logic           push;

    assign head_res  = result_data[head_tag];
    assign take_jump = accept && head_res.jump && !head_res.trap;
    assign push      = issue_valid && issue_ready;

    hsv_core_commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_core),
        .rst      (rst_core),
        .push     (push),
        .push_tag (exec_unit_t'(issue_unit)),
        .pop      (accept),
        .clear    (take_jump),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) state_q <= COMMIT_RUN;
        else          state_q <= state_d;
    end

    // Readies depend only on registered state, pointers and result_valid.
    always_comb begin
        state_d      = state_q;
        issue_ready  = 1'b0;
        result_ready = '0;
        accept       = 1'b0;
        case (state_q)
            COMMIT_RUN: begin
                issue_ready = !fifo_full;
                if (!fifo_empty) begin
                    result_ready[head_tag] = result_valid[head_tag];
                    accept                 = result_valid[head_tag];
                end
                if (accept) begin
                    if (head_res.trap)      state_d = COMMIT_HALT;
                    else if (head_res.jump) state_d = COMMIT_FLUSH;
                end
            end
            COMMIT_FLUSH: begin
                result_ready = '1;
                state_d      = COMMIT_RUN;
            end
            COMMIT_HALT: begin
                state_d = COMMIT_HALT;
            end
            default: begin
                state_d = COMMIT_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_valid <= 1'b0;
            commit_data  <= '0;
            flush        <= 1'b0;
            flush_target <= '0;
            halted       <= 1'b0;
        end else begin
            rf_we        <= accept && head_res.writeback &&
                            (head_res.rd != 5'd0) && !head_res.trap;
            commit_valid <= accept;
            flush        <= take_jump;
            if (accept) begin
                rf_waddr       <= head_res.rd;
                rf_wdata       <= head_res.rd_value;
                commit_data.pc <= head_res.pc;
            end
            if (take_jump)                 flush_target <= head_res.jump_target;
            if (accept && head_res.trap)   halted       <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hsv_core_commit.sv
// ============================================================================
// Module      : tb_hsv_core_commit
// Description : Directed self-checking bench for the in-order commit stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsv_core_commit;
    import hsv_core_pkg::*;

    logic                 clk_core;
    logic                 rst_core;
    logic                 issue_valid;
    logic [1:0]           issue_unit;
    logic                 issue_ready;
    logic [3:0]           result_valid;
    logic [3:0]           result_ready;
    commit_result_t [3:0] result_data;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic                 commit_valid;
    commit_data_t         commit_data;
    logic                 flush;
    logic [31:0]          flush_target;
    logic                 halted;

    int n_cmp;
    int n_fail;

    hsv_core_commit #(.DEPTH(8)) dut (
        .clk_core     (clk_core),
        .rst_core     (rst_core),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_ready  (issue_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_data  (commit_data),
        .flush        (flush),
        .flush_target (flush_target),
        .halted       (halted)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic set_res(input int u, input logic [31:0] pc, input logic [4:0] rd,
                           input logic [31:0] val, input logic wb, input logic jmp,
                           input logic [31:0] jt, input logic trp);
        logic [1:0] idx;
        idx = u[1:0];
        result_data[idx].pc          = pc;
        result_data[idx].rd          = rd;
        result_data[idx].rd_value    = val;
        result_data[idx].writeback   = wb;
        result_data[idx].jump        = jmp;
        result_data[idx].jump_target = jt;
        result_data[idx].trap        = trp;
        result_valid[idx]            = 1'b1;
    endtask

    task automatic push_tag(input logic [1:0] u);
        issue_valid = 1'b1;
        issue_unit  = u;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst_core     = 1'b1;
        issue_valid  = 1'b0;
        issue_unit   = 2'd0;
        result_valid = 4'b0;
        result_data  = '0;
        repeat (2) @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        #1;

        // Reset state
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_pc", commit_data.pc, 32'd0);
        chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        chk("rst_result_ready", {28'b0, result_ready}, 32'd0);

        // Ordering: MEM result offered first must wait behind ALU
        push_tag(2'd0);
        push_tag(2'd1);
        set_res(1, 32'h104, 5'd6, 32'h1111, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("ord_mem_held_ready", {28'b0, result_ready}, 32'h0);
        tick();
        chk("ord_mem_held_commit", {31'b0, commit_valid}, 32'd0);
        set_res(0, 32'h100, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("ord_alu_ready", {28'b0, result_ready}, 32'h1);
        tick();
        result_valid[0] = 1'b0;
        chk("ord_c1_valid", {31'b0, commit_valid}, 32'd1);
        chk("ord_c1_pc", commit_data.pc, 32'h100);
        chk("ord_c1_we", {31'b0, rf_we}, 32'd1);
        chk("ord_c1_waddr", {27'b0, rf_waddr}, 32'd5);
        chk("ord_c1_wdata", rf_wdata, 32'hDEADBEEF);
        #1;
        chk("ord_mem_ready", {28'b0, result_ready}, 32'h2);
        tick();
        result_valid[1] = 1'b0;
        chk("ord_c2_valid", {31'b0, commit_valid}, 32'd1);
        chk("ord_c2_pc", commit_data.pc, 32'h104);
        chk("ord_c2_we", {31'b0, rf_we}, 32'd0);
        tick();
        chk("ord_idle_valid", {31'b0, commit_valid}, 32'd0);

        // x0 and no-writeback retire without register writes
        push_tag(2'd0);
        push_tag(2'd0);
        set_res(0, 32'h200, 5'd0, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("x0_valid", {31'b0, commit_valid}, 32'd1);
        chk("x0_pc", commit_data.pc, 32'h200);
        chk("x0_we", {31'b0, rf_we}, 32'd0);
        set_res(0, 32'h204, 5'd3, 32'h66, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        result_valid = 4'b0;
        chk("nowb_valid", {31'b0, commit_valid}, 32'd1);
        chk("nowb_pc", commit_data.pc, 32'h204);
        chk("nowb_we", {31'b0, rf_we}, 32'd0);
        tick();
        chk("nowb_idle", {31'b0, commit_valid}, 32'd0);

        // Full: 8 tags, 9th push refused
        for (int i = 0; i < 8; i++) push_tag(2'(i % 2));
        chk("full_issue_ready", {31'b0, issue_ready}, 32'd0);
        push_tag(2'd3);
        chk("full_still_full", {31'b0, issue_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            result_valid = 4'b0;
            set_res(i % 2, 32'h300 + 32'(4 * i), 5'd1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
            chk("b1_valid", {31'b0, commit_valid}, 32'd1);
            chk("b1_pc", commit_data.pc, 32'h300 + 32'(4 * i));
        end
        result_valid = 4'b0;
        tick();
        chk("b1_drained_valid", {31'b0, commit_valid}, 32'd0);
        chk("b1_drained_ready", {31'b0, issue_ready}, 32'd1);

        // Wrap: 8 more tags; all units offer distinct data, head mux must choose
        for (int i = 0; i < 8; i++) push_tag(2'(i % 4));
        chk("wrap_full", {31'b0, issue_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            for (int u = 0; u < 4; u++)
                set_res(u, 32'h400 + 32'(16 * i + u), 5'(u + 1), 32'hA0 + 32'(u),
                        1'b1, 1'b0, 32'h0, 1'b0);
            tick();
            chk("b2_valid", {31'b0, commit_valid}, 32'd1);
            chk("b2_pc", commit_data.pc, 32'h400 + 32'(16 * i + (i % 4)));
            chk("b2_wdata", rf_wdata, 32'hA0 + 32'(i % 4));
        end
        result_valid = 4'b0;
        tick();
        chk("b2_drained", {31'b0, commit_valid}, 32'd0);

        // Flush: taken branch with a same-cycle push attempt
        push_tag(2'd2);
        push_tag(2'd0);
        push_tag(2'd0);
        set_res(2, 32'h500, 5'd0, 32'h0, 1'b0, 1'b1, 32'h2000, 1'b0);
        issue_valid = 1'b1;
        issue_unit  = 2'd3;
        tick();
        issue_valid = 1'b0;
        result_valid = 4'b0;
        chk("fl_flush", {31'b0, flush}, 32'd1);
        chk("fl_target", flush_target, 32'h2000);
        chk("fl_commit_pc", commit_data.pc, 32'h500);
        chk("fl_issue_ready", {31'b0, issue_ready}, 32'd0);
        set_res(0, 32'h600, 5'd4, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("fl_all_ready", {28'b0, result_ready}, 32'hF);
        tick();
        chk("fl_stale_no_commit", {31'b0, commit_valid}, 32'd0);
        chk("fl_flush_pulse", {31'b0, flush}, 32'd0);
        chk("fl_empty_ready", {28'b0, result_ready}, 32'h0);
        chk("fl_issue_back", {31'b0, issue_ready}, 32'd1);
        result_valid = 4'b0;
        push_tag(2'd0);
        set_res(3, 32'h6FC, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        set_res(0, 32'h610, 5'd8, 32'h88, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("fl_dropped_push", {28'b0, result_ready}, 32'h1);
        tick();
        result_valid = 4'b0;
        chk("fl_after_pc", commit_data.pc, 32'h610);

        // Trap with jump: trap wins, core halts
        push_tag(2'd3);
        set_res(3, 32'h700, 5'd7, 32'h99, 1'b1, 1'b1, 32'h3000, 1'b1);
        tick();
        chk("trap_halted", {31'b0, halted}, 32'd1);
        chk("trap_flush", {31'b0, flush}, 32'd0);
        chk("trap_we", {31'b0, rf_we}, 32'd0);
        chk("trap_commit_pc", commit_data.pc, 32'h700);
        result_valid = 4'hF;
        issue_valid  = 1'b1;
        repeat (5) tick();
        chk("halt_issue_ready", {31'b0, issue_ready}, 32'd0);
        chk("halt_result_ready", {28'b0, result_ready}, 32'h0);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        issue_valid  = 1'b0;
        result_valid = 4'b0;

        // Async reset out of HALT, then mid-cycle reset with tags pending
        #2 rst_core = 1'b1;
        #2 rst_core = 1'b0;
        tick();
        chk("rst1_halted", {31'b0, halted}, 32'd0);
        push_tag(2'd0);
        push_tag(2'd1);
        push_tag(2'd1);
        push_tag(2'd1);
        set_res(0, 32'h800, 5'd9, 32'hCAFE, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        result_valid = 4'b0;
        chk("pre_rst_we", {31'b0, rf_we}, 32'd1);
        #2 rst_core = 1'b1;
        #1;
        chk("arst_we", {31'b0, rf_we}, 32'd0);
        chk("arst_commit_valid", {31'b0, commit_valid}, 32'd0);
        chk("arst_waddr", {27'b0, rf_waddr}, 32'd0);
        chk("arst_wdata", rf_wdata, 32'd0);
        chk("arst_pc", commit_data.pc, 32'd0);
        chk("arst_issue_ready", {31'b0, issue_ready}, 32'd1);
        #2 rst_core = 1'b0;
        tick();
        result_valid = 4'hF;
        #1;
        chk("post_rst_empty", {28'b0, result_ready}, 32'h0);
        chk("post_rst_issue", {31'b0, issue_ready}, 32'd1);
        tick();
        chk("post_rst_no_commit", {31'b0, commit_valid}, 32'd0);
        result_valid = 4'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hsv_core_commit.md
# hsv_core_commit

In-order commit stage at the far end of the execute interface. It receives completed results from the four execution units (ALU, memory, branch, control/status) over per-unit valid/ready ports. It retires them in program order using an order FIFO that the issue stage fills, one unit tag per issued instruction. Each retired instruction produces a register-file write, a `commit_data_t` record, and, for taken control transfers, a pipeline flush.

## Interface

Parameters:
- `DEPTH`, default 8: order-FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk_core`  in  1  core clock
- `rst_core`  in  1  reset; asynchronous, active-high
- `issue_valid`  in  1  issue stage pushes one instruction tag
- `issue_unit`  in  2  `exec_unit_t` of the pushed instruction: 0 ALU, 1 MEM, 2 BRANCH, 3 CTRL_STATUS
- `issue_ready`  out  1  tag accepted when `issue_valid && issue_ready`
- `result_valid`  in  4  per-unit result valid, indexed by `exec_unit_t`
- `result_ready`  out  4  per-unit result accept
- `result_data`  in  4×`commit_result_t`  per-unit result record
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  register-file write address
- `rf_wdata`  out  32  register-file write data
- `commit_valid`  out  1  one instruction retired this cycle
- `commit_data`  out  `commit_data_t`  retired instruction (pc)
- `flush`  out  1  one-cycle pipeline flush request
- `flush_target`  out  32  refetch pc, valid while `flush`=1
- `halted`  out  1  trap retired; core stopped

## Operation

- **Order FIFO.** Circular buffer of `DEPTH` 2-bit unit tags. Pointers are `$clog2(DEPTH)+1` bits wide, with the MSB used for full/empty.
  - Empty: pointers equal.
  - Full: pointers equal except the MSB.
  - Pointers wrap naturally.
- **`issue_ready`.** Equals `!full && state==RUN`. A pop in the same cycle does not free a slot for a push in that cycle.
- **Head match.** With state RUN and the FIFO non-empty, let `h` be the head tag. Then `result_ready[h] = result_valid[h]`; all other `result_ready` bits are 0. Results from non-head units wait.
- **Accept.** When `result_valid[h] && result_ready[h]`, the FIFO pops and the output registers load.
  - `rf_we` = `writeback && rd != 0`; `rf_waddr` = `rd`; `rf_wdata` = `rd_value`.
  - `commit_valid` = 1; `commit_data.pc` = `pc`.
  - If `jump`: `flush` = 1, `flush_target` = `jump_target`.
  - If `trap`: `rf_we` = 0, `flush` = 0, `halted` = 1.
- **States:**
  - **RUN** is the reset state.
  - **RUN → FLUSH** on accepting a `jump` result. At that same edge the FIFO clears (both pointers to 0) and any same-cycle push is dropped.
  - **FLUSH** lasts exactly 1 cycle. All `result_ready` = 1 and incoming results are discarded without commit. `issue_ready` = 0. Then FLUSH → RUN.
  - **RUN → HALT** on accepting a `trap` result. HALT is terminal until reset: `issue_ready` = 0, all `result_ready` = 0, `halted` = 1.
  - If `jump` and `trap` are both set, `trap` wins.
- **Reset (asynchronous, any cycle):**
  - State RUN, pointers 0.
  - Outputs: `rf_we`, `commit_valid`, `flush`, `halted` = 0; `rf_waddr` = 0; `rf_wdata`, `flush_target`, `commit_data` = 0.
  - Any in-flight entries are lost.

## Timing

- Result accepted at edge N; `rf_*`, `commit_*` and `flush*` are valid during cycle N+1 for exactly one cycle.
- `rf_we`, `commit_valid` and `flush` are registered one-cycle pulses.
- `result_ready` and `issue_ready` are combinational from the registered state and pointers, plus `result_valid` for `result_ready` only. There is no path from `result_data` to any ready.
- Sustained throughput is 1 commit per cycle when the head result is always valid.
- A tag pushed at edge N is a head candidate from cycle N+1; the earliest commit is edge N+1, with outputs in cycle N+2.
- `flush` is asserted during the FLUSH cycle.

## Structure

- Add to `hsv_core_pkg`:
  - `exec_unit_t`: 2-bit enum `EXEC_ALU`, `EXEC_MEM`, `EXEC_BRANCH`, `EXEC_CTRL_STATUS`.
  - `commit_result_t`: packed struct with fields `word pc`, `logic [4:0] rd`, `word rd_value`, `logic writeback`, `logic jump`, `word jump_target`, `logic trap`.
  - `commit_state_t`: `COMMIT_RUN`, `COMMIT_FLUSH`, `COMMIT_HALT`.
  - Existing `commit_data_t` is reused for `commit_data`.
- One sub-module: `hsv_core_commit_fifo`, the parameterized tag FIFO with push, pop, clear, full and empty.
- The FSM, head mux and output registers live in the top module.

## Test plan

- **Ordering.** Push tags ALU, MEM. Assert MEM result (pc=0x104) first, then ALU (pc=0x100, rd=5, value=0xDEADBEEF). → MEM is held until the ALU retires. Commits appear as pc 0x100 then 0x104, with rf_we/rf_waddr=5/rf_wdata=0xDEADBEEF on the first.
- **x0 / no-writeback.** Retire rd=0, writeback=1; then rd=3, writeback=0. → `commit_valid` pulses twice, `rf_we` stays 0.
- **Full/wrap.** Push 8 tags with DEPTH=8. → `issue_ready`=0. Retire all 8, then push 8 more. → all commit in order and the pointers wrap correctly.
- **Flush.** Push BRANCH, ALU, ALU. Branch result has jump=1, jump_target=0x2000, and a push is attempted in the same cycle. → `flush`=1 with `flush_target`=0x2000 one cycle later. FIFO is empty. A stale ALU result offered during FLUSH is consumed with no commit. The dropped push does not appear.
- **Trap.** Retire CTRL_STATUS result with trap=1, jump=1. → `halted`=1, `flush`=0, `rf_we`=0. Afterwards `issue_ready` and `result_ready` stay 0 indefinitely.
- **Async reset.** Assert `rst_core` between clock edges with 3 tags pending. → all outputs reach reset values immediately. After release `issue_ready`=1 and the FIFO is empty.
